// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage of the 64-bit pipeline.
package fetch_stage_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;

    localparam logic [PC_W-1:0]   DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;
    localparam logic [INST_W-1:0] NOP_INST         = 32'hD503_201F;
    localparam logic [PC_W-1:0]   PC_STEP          = 64'h0000_0000_0000_0004;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_BUBBLE = 2'd3
    } fetch_state_t;

    // Sequential fetch address; wraps modulo 2^PC_W without any flag.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] inst_out;
    logic [PC_W-1:0]   pc_out;
    logic              valid_out;

    // Environment side: hazard unit, branch unit, memory and IF/ID register.
    modport master (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, inst_out, pc_out, valid_out
    );

    // Fetch stage side.
    modport slave (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, inst_out, pc_out, valid_out
    );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// PC-wide register with synchronous reset and load enable.
module fetch_stage_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RST_VAL = 64'h0000_0000_0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [PC_W-1:0] d_i,
    output logic [PC_W-1:0] q_o
);

    logic [PC_W-1:0] value_q;

    // Reset dominates; otherwise capture d_i only when loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RST_VAL;
        end else if (load_i) begin
            value_q <= d_i;
        end else begin
            value_q <= value_q;
        end
    end

    assign q_o = value_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous instruction memory,
// and absorbs stall/redirect by holding or squashing what it presents to IF/ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  fif
);

    fetch_state_t      state_q,     state_d;
    logic [INST_W-1:0] hold_inst_q, hold_inst_d;

    logic              issue_ld_s;
    logic [PC_W-1:0]   issue_pc_d, issue_pc_q;
    logic              resp_ld_s;
    logic [PC_W-1:0]   resp_pc_q;

    // issue_pc is the address currently presented to memory.
    fetch_stage_pc_reg #(.RST_VAL(RESET_PC)) u_issue_pc (
        .clk    (clk),
        .reset  (reset),
        .load_i (issue_ld_s),
        .d_i    (issue_pc_d),
        .q_o    (issue_pc_q)
    );

    // resp_pc is the address whose data is now on imem_rdata.
    fetch_stage_pc_reg #(.RST_VAL(64'h0000_0000_0000_0000)) u_resp_pc (
        .clk    (clk),
        .reset  (reset),
        .load_i (resp_ld_s),
        .d_i    (issue_pc_q),
        .q_o    (resp_pc_q)
    );

    // State and held-instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            hold_inst_q <= NOP_INST;
        end else begin
            state_q     <= state_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    // Next-state logic: redirect beats stall, stall beats advance.
    always_comb begin
        state_d     = state_q;
        hold_inst_d = hold_inst_q;
        issue_ld_s  = 1'b0;
        issue_pc_d  = issue_pc_q;
        resp_ld_s   = 1'b0;

        if (fif.redirect) begin
            issue_ld_s  = 1'b1;
            issue_pc_d  = fif.redirect_pc;
            hold_inst_d = NOP_INST;
            state_d     = ST_BUBBLE;
        end else begin
            case (state_q)
                ST_BOOT, ST_BUBBLE: begin
                    if (!fif.stall) begin
                        resp_ld_s  = 1'b1;
                        issue_ld_s = 1'b1;
                        issue_pc_d = pc_next(issue_pc_q);
                        state_d    = ST_RUN;
                    end else begin
                        state_d    = state_q;
                    end
                end
                ST_RUN: begin
                    if (fif.stall) begin
                        hold_inst_d = fif.imem_rdata;
                        state_d     = ST_HOLD;
                    end else begin
                        resp_ld_s  = 1'b1;
                        issue_ld_s = 1'b1;
                        issue_pc_d = pc_next(issue_pc_q);
                        state_d    = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    // Memory has been re-reading issue_pc throughout, so resuming loses nothing.
                    if (!fif.stall) begin
                        resp_ld_s  = 1'b1;
                        issue_ld_s = 1'b1;
                        issue_pc_d = pc_next(issue_pc_q);
                        state_d    = ST_RUN;
                    end else begin
                        state_d    = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // Output mux; reset and redirect cycles always present a bubble.
    always_comb begin
        fif.inst_out  = NOP_INST;
        fif.pc_out    = 64'h0000_0000_0000_0000;
        fif.valid_out = 1'b0;

        if (reset || fif.redirect) begin
            fif.inst_out  = NOP_INST;
            fif.pc_out    = 64'h0000_0000_0000_0000;
            fif.valid_out = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    fif.inst_out  = fif.imem_rdata;
                    fif.pc_out    = resp_pc_q;
                    fif.valid_out = 1'b1;
                end
                ST_HOLD: begin
                    fif.inst_out  = hold_inst_q;
                    fif.pc_out    = resp_pc_q;
                    fif.valid_out = 1'b1;
                end
                default: begin
                    fif.inst_out  = NOP_INST;
                    fif.pc_out    = 64'h0000_0000_0000_0000;
                    fif.valid_out = 1'b0;
                end
            endcase
        end
    end

    assign fif.imem_addr = issue_pc_q;

    // Misaligned redirect targets are fetched as given but flagged.
    always @(posedge clk) begin
        if (!reset && fif.redirect) begin
            assert (fif.redirect_pc[1:0] == 2'b00)
                else $error("misaligned redirect_pc %h", fif.redirect_pc);
        end
    end

endmodule
